game_timer: RTL and testbench

GAME_TIMER -- requirements
Module: game_timer

---
 rtl/game_timer_pkg.sv | 31 +++
 rtl/game_timer_bcd_digit.sv | 56 +++++
 rtl/game_timer.sv | 180 ++++++++++++++++++
 tb/tb_game_timer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_timer_pkg.sv
// -----------------------------------------------------------------------------
// game_timer_pkg
// Shared definitions for the game timer slice.
//   timer_state_t : FSM states IDLE, RUN, PAUSE, DONE
//   BCD_DIGIT_W   : width of one BCD digit (4)
//   BCD_DIGITS    : number of BCD digits presented on bcd (3)
//   to_bcd3()     : elaboration-time helper turning a constant count into its
//                   three-digit BCD image (used only for reload constants)
// Optional feature macro used by importers: GAME_TIMER_BCD_EN
// -----------------------------------------------------------------------------
package game_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timer_state_t;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_DIGITS  = 3;

  // Only ever called with constant arguments, so the divides fold away at
  // elaboration and produce no hardware.
  function automatic logic [11:0] to_bcd3(input int value);
    int v;
    v = value % 1000;
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/game_timer_bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// One decimal digit of a chained BCD up/down counter. A digit steps only when
// carry_in is high; carry_out tells the next digit to step in the same cycle
// (up: digit rolls 9 -> 0, down: digit rolls 0 -> 9).
// Ports:
//   CLOCK_50   in   clock, rising edge
//   load       in   synchronous load of load_value (overrides stepping)
//   load_value in   [3:0] value to load
//   down       in   1 = decrement, 0 = increment
//   carry_in   in   step enable from the lower digit (or the count step)
//   carry_out  out  step enable for the next higher digit (combinational)
//   digit      out  [3:0] registered digit value
// Instantiated by game_timer only when GAME_TIMER_BCD_EN is defined.
// -----------------------------------------------------------------------------
module bcd_digit
  import game_timer_pkg::*;
(
  input  logic                   CLOCK_50,
  input  logic                   load,
  input  logic [BCD_DIGIT_W-1:0] load_value,
  input  logic                   down,
  input  logic                   carry_in,
  output logic                   carry_out,
  output logic [BCD_DIGIT_W-1:0] digit
);

  logic [BCD_DIGIT_W-1:0] digit_reg;
  logic [BCD_DIGIT_W-1:0] digit_next;

  always_comb begin
    digit_next = digit_reg;
    if (carry_in) begin
      if (down) begin
        digit_next = (digit_reg == 4'd0) ? 4'd9 : digit_reg - 4'd1;
      end else begin
        digit_next = (digit_reg == 4'd9) ? 4'd0 : digit_reg + 4'd1;
      end
    end
  end

  // Borrow/carry ripples combinationally so every digit updates on the same
  // edge as the binary count.
  assign carry_out = carry_in & (down ? (digit_reg == 4'd0) : (digit_reg == 4'd9));

  always_ff @(posedge CLOCK_50) begin
    if (load) begin
      digit_reg <= load_value;
    end else begin
      digit_reg <= digit_next;
    end
  end

  assign digit = digit_reg;

endmodule

// File: rtl/game_timer.sv
// -----------------------------------------------------------------------------
// game_timer
// Seconds timer with start / pause / stop / clear control. A prescaler divides
// CLOCK_50 down to one tick per CLK_HZ running cycles; each tick steps the
// seconds count up from 0 or down from MAX_COUNT until the terminal value.
// Parameters:
//   CLK_HZ     CLOCK_50 cycles per one-second tick
//   COUNT_W    width of the seconds count
//   MAX_COUNT  terminal count value
//   COUNT_DOWN 0 = count up from 0, 1 = count down from MAX_COUNT
// Ports:
//   CLOCK_50 in   clock, rising edge
//   reset    in   synchronous active-high reset
//   start    in   begin (from IDLE) or resume (from PAUSE)
//   pause    in   freeze timing in RUN, prescaler value kept
//   stop     in   end timing from RUN/PAUSE, count frozen, expired stays 0
//   clear    in   back to IDLE with the initial count reloaded
//   count    out  [COUNT_W-1:0] registered seconds value
//   tick     out  one-cycle pulse in the cycle count changes
//   running  out  high only in RUN
//   expired  out  high only in DONE reached through the terminal count
//   bcd      out  [11:0] BCD image of count (hundreds, tens, ones)
// Optional feature: define GAME_TIMER_BCD_EN to build the BCD digit chain;
// otherwise bcd is tied to 12'h000.
// -----------------------------------------------------------------------------
module game_timer
  import game_timer_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int COUNT_W    = 10,
  parameter int MAX_COUNT  = 999,
  parameter int COUNT_DOWN = 0
)(
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic               stop,
  input  logic               clear,
  output logic [COUNT_W-1:0] count,
  output logic               tick,
  output logic               running,
  output logic               expired,
  output logic [11:0]        bcd
);

  localparam int                 PRE_W      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(CLK_HZ - 1);
  localparam logic [COUNT_W-1:0] INIT_COUNT = (COUNT_DOWN != 0) ? COUNT_W'(MAX_COUNT) : '0;
  localparam logic [COUNT_W-1:0] TERM_COUNT = (COUNT_DOWN != 0) ? '0 : COUNT_W'(MAX_COUNT);

  timer_state_t       state_reg;
  logic [PRE_W-1:0]   prescaler_reg;
  logic [COUNT_W-1:0] count_reg;
  logic               tick_reg;
  logic               running_reg;
  logic               expired_reg;

  logic               at_wrap;
  logic               stop_applies;
  logic               count_step;
  logic [COUNT_W-1:0] count_next;

  assign at_wrap      = (prescaler_reg == PRE_LAST);
  // stop only outranks lower commands when it actually has an effect.
  assign stop_applies = stop && ((state_reg == RUN) || (state_reg == PAUSE));
  // A tick edge coinciding with stop or clear does not step the count.
  assign count_step   = (state_reg == RUN) && at_wrap && !clear && !stop;
  assign count_next   = (COUNT_DOWN != 0) ? count_reg - COUNT_W'(1)
                                          : count_reg + COUNT_W'(1);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg     <= IDLE;
      prescaler_reg <= '0;
      count_reg     <= INIT_COUNT;
      tick_reg      <= 1'b0;
      running_reg   <= 1'b0;
      expired_reg   <= 1'b0;
    end else begin
      tick_reg <= 1'b0;
      if (clear) begin
        state_reg     <= IDLE;
        prescaler_reg <= '0;
        count_reg     <= INIT_COUNT;
        running_reg   <= 1'b0;
        expired_reg   <= 1'b0;
      end else if (stop_applies) begin
        state_reg   <= DONE;
        running_reg <= 1'b0;
        expired_reg <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start) begin
              state_reg     <= RUN;
              prescaler_reg <= '0;
              running_reg   <= 1'b1;
            end
          end
          RUN: begin
            if (at_wrap) begin
              prescaler_reg <= '0;
              count_reg     <= count_next;
              tick_reg      <= 1'b1;
              // Reaching the terminal value wins over a coincident pause.
              if (count_next == TERM_COUNT) begin
                state_reg   <= DONE;
                running_reg <= 1'b0;
                expired_reg <= 1'b1;
              end else if (pause) begin
                state_reg   <= PAUSE;
                running_reg <= 1'b0;
              end
            end else if (pause) begin
              // Prescaler is held so the partial second survives the pause.
              state_reg   <= PAUSE;
              running_reg <= 1'b0;
            end else begin
              prescaler_reg <= prescaler_reg + PRE_W'(1);
            end
          end
          PAUSE: begin
            if (start) begin
              state_reg   <= RUN;
              running_reg <= 1'b1;
            end
          end
          DONE: begin
            // Only clear (handled above) leaves DONE.
          end
          default: begin
            state_reg   <= IDLE;
            running_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count   = count_reg;
  assign tick    = tick_reg;
  assign running = running_reg;
  assign expired = expired_reg;

`ifdef GAME_TIMER_BCD_EN
  localparam logic [11:0] INIT_BCD = to_bcd3((COUNT_DOWN != 0) ? MAX_COUNT : 0);

  if (MAX_COUNT > 999) begin : g_max_check
    $error("game_timer: MAX_COUNT %0d does not fit three BCD digits", MAX_COUNT);
  end

  logic [BCD_DIGITS:0] bcd_carry;
  logic                bcd_load;
  logic                bcd_down;
  logic                bcd_carry_unused;

  // The ones digit steps exactly when the binary count steps; higher digits
  // follow through the carry chain in the same cycle.
  assign bcd_carry[0]     = count_step;
  assign bcd_load         = reset | clear;
  assign bcd_down         = (COUNT_DOWN != 0);
  assign bcd_carry_unused = bcd_carry[BCD_DIGITS];

  for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
    bcd_digit u_digit (
      .CLOCK_50   (CLOCK_50),
      .load       (bcd_load),
      .load_value (INIT_BCD[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .down       (bcd_down),
      .carry_in   (bcd_carry[gi]),
      .carry_out  (bcd_carry[gi+1]),
      .digit      (bcd[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end
`else
  assign bcd = 12'h000;
`endif

endmodule

// File: tb/tb_game_timer.sv
// -----------------------------------------------------------------------------
// tb_game_timer
// Three timer instances share one command bus:
//   u_up : CLK_HZ=4, up-count, MAX_COUNT=999
//   u_m5 : CLK_HZ=4, up-count, MAX_COUNT=5
//   u_dn : CLK_HZ=4, down-count, MAX_COUNT=3
// Directed scenario tasks plus a randomized phase checked against a
// behavioural model that tracks elapsed running cycles per second.
// -----------------------------------------------------------------------------
module tb_game_timer;

  localparam int HZ = 4;

  logic CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  logic reset = 1'b1;
  logic start = 1'b0;
  logic pause = 1'b0;
  logic stop  = 1'b0;
  logic clear = 1'b0;

  logic [9:0]  cnt_up, cnt_m5, cnt_dn;
  logic        tick_up, tick_m5, tick_dn;
  logic        run_up, run_m5, run_dn;
  logic        exp_up, exp_m5, exp_dn;
  logic [11:0] bcd_up, bcd_m5, bcd_dn;

  game_timer #(.CLK_HZ(HZ), .COUNT_W(10), .MAX_COUNT(999), .COUNT_DOWN(0)) u_up (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .pause(pause), .stop(stop),
    .clear(clear), .count(cnt_up), .tick(tick_up), .running(run_up),
    .expired(exp_up), .bcd(bcd_up));

  game_timer #(.CLK_HZ(HZ), .COUNT_W(10), .MAX_COUNT(5), .COUNT_DOWN(0)) u_m5 (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .pause(pause), .stop(stop),
    .clear(clear), .count(cnt_m5), .tick(tick_m5), .running(run_m5),
    .expired(exp_m5), .bcd(bcd_m5));

  game_timer #(.CLK_HZ(HZ), .COUNT_W(10), .MAX_COUNT(3), .COUNT_DOWN(1)) u_dn (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .pause(pause), .stop(stop),
    .clear(clear), .count(cnt_dn), .tick(tick_dn), .running(run_dn),
    .expired(exp_dn), .bcd(bcd_dn));

  logic [9:0]  o_count [3];
  logic        o_tick  [3];
  logic        o_run   [3];
  logic        o_exp   [3];
  logic [11:0] o_bcd   [3];
  assign o_count[0] = cnt_up;  assign o_count[1] = cnt_m5;  assign o_count[2] = cnt_dn;
  assign o_tick[0]  = tick_up; assign o_tick[1]  = tick_m5; assign o_tick[2]  = tick_dn;
  assign o_run[0]   = run_up;  assign o_run[1]   = run_m5;  assign o_run[2]   = run_dn;
  assign o_exp[0]   = exp_up;  assign o_exp[1]   = exp_m5;  assign o_exp[2]   = exp_dn;
  assign o_bcd[0]   = bcd_up;  assign o_bcd[1]   = bcd_m5;  assign o_bcd[2]   = bcd_dn;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------------------------------------------------------------------
  // Reference model: seconds value, running cycles elapsed in the current
  // second, and the mode flags.
  // ---------------------------------------------------------------------------
  typedef struct {
    int seconds;
    int elapsed;
    bit is_running;
    bit is_paused;
    bit is_done;
    bit hit_end;
    bit pulse;
  } model_t;

  model_t mdl [3];

  function automatic int p_max(input int i);
    return (i == 0) ? 999 : (i == 1) ? 5 : 3;
  endfunction

  function automatic bit p_down(input int i);
    return (i == 2);
  endfunction

  function automatic model_t model_step(input model_t m, input int i, input bit rst,
                                        input bit clr, input bit stp, input bit pse,
                                        input bit sta);
    model_t n;
    int first_val, last_val;
    n = m;
    first_val = p_down(i) ? p_max(i) : 0;
    last_val  = p_down(i) ? 0 : p_max(i);
    n.pulse = 1'b0;
    if (rst || clr) begin
      n.seconds = first_val; n.elapsed = 0;
      n.is_running = 0; n.is_paused = 0; n.is_done = 0; n.hit_end = 0;
    end else if (stp && (m.is_running || m.is_paused)) begin
      n.is_running = 0; n.is_paused = 0; n.is_done = 1; n.hit_end = 0;
    end else if (m.is_running) begin
      if (m.elapsed + 1 == HZ) begin
        n.elapsed = 0;
        n.seconds = p_down(i) ? m.seconds - 1 : m.seconds + 1;
        n.pulse   = 1'b1;
        if (n.seconds == last_val) begin
          n.is_running = 0; n.is_done = 1; n.hit_end = 1;
        end else if (pse) begin
          n.is_running = 0; n.is_paused = 1;
        end
      end else if (pse) begin
        n.is_running = 0; n.is_paused = 1;
      end else begin
        n.elapsed = m.elapsed + 1;
      end
    end else if (m.is_paused) begin
      if (sta) begin n.is_paused = 0; n.is_running = 1; end
    end else if (!m.is_done) begin
      if (sta) begin n.is_running = 1; n.elapsed = 0; end
    end
    return n;
  endfunction

  always @(posedge CLOCK_50) begin
    for (int i = 0; i < 3; i++) begin
      mdl[i] <= model_step(mdl[i], i, reset, clear, stop, pause, start);
    end
  end

  function automatic logic [11:0] exp_bcd(input int c);
`ifdef GAME_TIMER_BCD_EN
    return {4'(c / 100), 4'((c / 10) % 10), 4'(c % 10)};
`else
    return (c < 0) ? 12'hfff : 12'h000;
`endif
  endfunction

  // Drive one cycle of commands; outputs are stable on return.
  task automatic step(input bit sta, input bit pse, input bit stp, input bit clr,
                      input bit rst);
    start = sta; pause = pse; stop = stp; clear = clr; reset = rst;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset;
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    n_checks++; if (cnt_up !== 10'd0) begin n_fail++; $display("FAIL reset_count_up: got %0d want 0", cnt_up); end
    n_checks++; if (cnt_dn !== 10'd3) begin n_fail++; $display("FAIL reset_count_dn: got %0d want 3", cnt_dn); end
    n_checks++; if ({tick_up, run_up, exp_up} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {tick_up, run_up, exp_up}); end
    n_checks++; if (bcd_dn !== exp_bcd(3)) begin n_fail++; $display("FAIL reset_bcd_dn: got %h want %h", bcd_dn, exp_bcd(3)); end
    n_checks++; if (bcd_up !== exp_bcd(0)) begin n_fail++; $display("FAIL reset_bcd_up: got %h want %h", bcd_up, exp_bcd(0)); end
    step(0, 0, 0, 0, 0);
    $display("test_reset: done");
  endtask

  task automatic test_up_count;
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    n_checks++; if (run_up !== 1'b1 || cnt_up !== 10'd0) begin n_fail++; $display("FAIL start_run: got run=%b count=%0d want run=1 count=0", run_up, cnt_up); end
    for (int k = 1; k <= 3; k++) begin
      for (int c = 0; c < HZ - 1; c++) begin
        step(0, 0, 0, 0, 0);
        n_checks++; if (tick_up !== 1'b0 || cnt_up !== 10'(k - 1)) begin n_fail++; $display("FAIL up_between: got tick=%b count=%0d want tick=0 count=%0d", tick_up, cnt_up, k - 1); end
      end
      step(0, 0, 0, 0, 0);
      n_checks++; if (tick_up !== 1'b1 || cnt_up !== 10'(k) || run_up !== 1'b1) begin n_fail++; $display("FAIL up_tick: got tick=%b count=%0d run=%b want 1/%0d/1", tick_up, cnt_up, run_up, k); end
    end
    $display("test_up_count: count=%0d", cnt_up);
  endtask

  task automatic test_pause_resume;
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    idle(HZ);
    idle(2);
    step(0, 1, 0, 0, 0);
    n_checks++; if (run_up !== 1'b0 || cnt_up !== 10'd1) begin n_fail++; $display("FAIL pause_enter: got run=%b count=%0d want 0/1", run_up, cnt_up); end
    for (int c = 0; c < 10; c++) begin
      step(0, 0, 0, 0, 0);
      n_checks++; if (cnt_up !== 10'd1 || tick_up !== 1'b0) begin n_fail++; $display("FAIL pause_hold: got count=%0d tick=%b want 1/0", cnt_up, tick_up); end
    end
    step(1, 0, 0, 0, 0);
    n_checks++; if (run_up !== 1'b1 || tick_up !== 1'b0) begin n_fail++; $display("FAIL resume: got run=%b tick=%b want 1/0", run_up, tick_up); end
    step(0, 0, 0, 0, 0);
    n_checks++; if (tick_up !== 1'b0) begin n_fail++; $display("FAIL resume_early_tick: got tick=%b want 0", tick_up); end
    step(0, 0, 0, 0, 0);
    n_checks++; if (tick_up !== 1'b1 || cnt_up !== 10'd2) begin n_fail++; $display("FAIL resume_tick: got tick=%b count=%0d want 1/2", tick_up, cnt_up); end
    $display("test_pause_resume: count=%0d", cnt_up);
  endtask

  task automatic test_terminal;
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    idle(5 * HZ - 1);
    n_checks++; if (cnt_m5 !== 10'd4 || exp_m5 !== 1'b0) begin n_fail++; $display("FAIL term_before: got count=%0d exp=%b want 4/0", cnt_m5, exp_m5); end
    step(0, 0, 0, 0, 0);
    n_checks++; if (cnt_m5 !== 10'd5 || exp_m5 !== 1'b1 || run_m5 !== 1'b0) begin n_fail++; $display("FAIL term_hit: got count=%0d exp=%b run=%b want 5/1/0", cnt_m5, exp_m5, run_m5); end
    for (int c = 0; c < 2 * HZ; c++) begin
      step(1, 0, 0, 0, 0);
      n_checks++; if (cnt_m5 !== 10'd5 || exp_m5 !== 1'b1 || run_m5 !== 1'b0 || tick_m5 !== 1'b0) begin n_fail++; $display("FAIL term_hold: got count=%0d exp=%b run=%b tick=%b", cnt_m5, exp_m5, run_m5, tick_m5); end
    end
    step(0, 0, 0, 1, 0);
    n_checks++; if (cnt_m5 !== 10'd0 || exp_m5 !== 1'b0) begin n_fail++; $display("FAIL term_clear: got count=%0d exp=%b want 0/0", cnt_m5, exp_m5); end
    step(1, 0, 0, 0, 0);
    n_checks++; if (run_m5 !== 1'b1) begin n_fail++; $display("FAIL term_restart: got run=%b want 1", run_m5); end
    $display("test_terminal: done");
  endtask

  task automatic test_count_down;
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      idle(HZ);
      n_checks++; if (cnt_dn !== 10'(3 - k) || tick_dn !== 1'b1) begin n_fail++; $display("FAIL down_step: got count=%0d tick=%b want %0d/1", cnt_dn, tick_dn, 3 - k); end
      n_checks++; if (bcd_dn !== exp_bcd(3 - k)) begin n_fail++; $display("FAIL down_bcd: got %h want %h", bcd_dn, exp_bcd(3 - k)); end
    end
    n_checks++; if (exp_dn !== 1'b1 || run_dn !== 1'b0) begin n_fail++; $display("FAIL down_expire: got exp=%b run=%b want 1/0", exp_dn, run_dn); end
    idle(2 * HZ);
    n_checks++; if (cnt_dn !== 10'd0 || exp_dn !== 1'b1) begin n_fail++; $display("FAIL down_hold: got count=%0d exp=%b want 0/1", cnt_dn, exp_dn); end
    $display("test_count_down: count=%0d", cnt_dn);
  endtask

  task automatic test_stop_on_tick;
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    idle(HZ);
    idle(HZ - 1);
    step(0, 0, 1, 0, 0);
    n_checks++; if (cnt_up !== 10'd1 || tick_up !== 1'b0 || run_up !== 1'b0 || exp_up !== 1'b0) begin n_fail++; $display("FAIL stop_tick: got count=%0d tick=%b run=%b exp=%b want 1/0/0/0", cnt_up, tick_up, run_up, exp_up); end
    step(1, 0, 0, 0, 0);
    idle(HZ);
    n_checks++; if (cnt_up !== 10'd1 || run_up !== 1'b0) begin n_fail++; $display("FAIL stop_done_hold: got count=%0d run=%b want 1/0", cnt_up, run_up); end
    $display("test_stop_on_tick: done");
  endtask

  task automatic test_reset_mid_run;
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    idle(HZ + 2);
    n_checks++; if (cnt_up !== 10'd1 || run_up !== 1'b1) begin n_fail++; $display("FAIL midrun_pre: got count=%0d run=%b want 1/1", cnt_up, run_up); end
    step(1, 1, 0, 0, 1);
    n_checks++; if (cnt_up !== 10'd0 || run_up !== 1'b0 || tick_up !== 1'b0) begin n_fail++; $display("FAIL midrun_reset: got count=%0d run=%b tick=%b want 0/0/0", cnt_up, run_up, tick_up); end
    idle(HZ + 1);
    n_checks++; if (cnt_up !== 10'd0 || run_up !== 1'b0) begin n_fail++; $display("FAIL midrun_idle: got count=%0d run=%b want 0/0", cnt_up, run_up); end
    $display("test_reset_mid_run: done");
  endtask

  task automatic test_bcd_rollover;
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    idle(99 * HZ);
    n_checks++; if (cnt_up !== 10'd99 || bcd_up !== exp_bcd(99)) begin n_fail++; $display("FAIL bcd_99: got count=%0d bcd=%h want 99/%h", cnt_up, bcd_up, exp_bcd(99)); end
    idle(HZ - 1);
    n_checks++; if (bcd_up !== exp_bcd(99)) begin n_fail++; $display("FAIL bcd_99_hold: got %h want %h", bcd_up, exp_bcd(99)); end
    step(0, 0, 0, 0, 0);
    n_checks++; if (cnt_up !== 10'd100 || bcd_up !== exp_bcd(100) || tick_up !== 1'b1) begin n_fail++; $display("FAIL bcd_100: got count=%0d bcd=%h tick=%b want 100/%h/1", cnt_up, bcd_up, tick_up, exp_bcd(100)); end
    $display("test_bcd_rollover: bcd=%h", bcd_up);
  endtask

  task automatic test_random;
    bit sta, pse, stp, clr, rst;
    step(0, 0, 0, 0, 1);
    for (int c = 0; c < 1500; c++) begin
      sta = ($urandom_range(0, 3) == 0);
      pse = ($urandom_range(0, 15) == 0);
      stp = ($urandom_range(0, 63) == 0);
      clr = ($urandom_range(0, 79) == 0);
      rst = ($urandom_range(0, 199) == 0);
      step(sta, pse, stp, clr, rst);
      for (int i = 0; i < 3; i++) begin
        n_checks++; if (o_count[i] !== 10'(mdl[i].seconds)) begin n_fail++; $display("FAIL rnd_count[%0d] cyc %0d: got %0d want %0d", i, c, o_count[i], mdl[i].seconds); end
        n_checks++; if (o_tick[i] !== mdl[i].pulse) begin n_fail++; $display("FAIL rnd_tick[%0d] cyc %0d: got %b want %b", i, c, o_tick[i], mdl[i].pulse); end
        n_checks++; if (o_run[i] !== mdl[i].is_running) begin n_fail++; $display("FAIL rnd_running[%0d] cyc %0d: got %b want %b", i, c, o_run[i], mdl[i].is_running); end
        n_checks++; if (o_exp[i] !== mdl[i].hit_end) begin n_fail++; $display("FAIL rnd_expired[%0d] cyc %0d: got %b want %b", i, c, o_exp[i], mdl[i].hit_end); end
        n_checks++; if (o_bcd[i] !== exp_bcd(mdl[i].seconds)) begin n_fail++; $display("FAIL rnd_bcd[%0d] cyc %0d: got %h want %h", i, c, o_bcd[i], exp_bcd(mdl[i].seconds)); end
      end
    end
    $display("test_random: 1500 cycles");
  endtask

  initial begin
    test_reset;
    test_up_count;
    test_pause_resume;
    test_terminal;
    test_count_down;
    test_stop_on_tick;
    test_reset_mid_run;
    test_bcd_rollover;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
